ad9958_write_scheduler: RTL and testbench
=========================================

// Module: ad9958_write_scheduler
// PURPOSE
//   Shares the four-bit SPI serializer between two register-write requesters (0 = host command
//   path, 1 = sweep/profile engine) with round-robin arbitration.
//   Turns each {addr, data} write into the serializer frame: data_input, packs_to_send, trigger.
//   Tracks serializer busy to completion; optionally pulses AD9958 IO_UPDATE afterwards.
//   Sits between the command logic and four_bit_spi in the AD9958 controller.
// PARAMETERS
//   BUSY_TIMEOUT     255  max cycles from trigger to busy rising before the write is abandoned
//   IO_UPDATE_WIDTH  4    io_update pulse length in clock cycles (>=1)
// PORTS
//   clock             in   1   system clock; all logic on rising edge
//   reset             in   1   synchronous, active-high reset
//   req_valid         in   2   per-requester write request
//   req_ready         out  2   per-requester accept; transfer when valid&&ready
//   req_addr          in   10  {addr1[4:0], addr0[4:0]} AD9958 register address
//   req_data          in   64  {data1[31:0], data0[31:0]} write data, right-justified
//   req_update        in   2   per-requester: pulse io_update after this write
//   spi_busy          in   1   serializer busy
//   spi_trigger       out  1   one-cycle start pulse to the serializer
//   spi_packs_to_send out  5   nibble count of the frame
//   spi_data_input    out  64  frame; nibble k (bits 4k+3:4k) is the k-th nibble sent
//   io_update         out  1   AD9958 IO_UPDATE
//   sched_busy        out  1   high whenever state != IDLE
//   err_addr          out  1   sticky: an address > 0x18 was accepted
//   err_timeout       out  1   sticky: busy never rose within BUSY_TIMEOUT
// BEHAVIOUR
//   Reset: state IDLE; outputs req_ready, spi_trigger, io_update, sched_busy, err_* = 0;
//     spi_packs_to_send = 0, spi_data_input = 0; RR pointer favours requester 0.
//   FSM: IDLE -> LOAD -> WAIT_HI -> WAIT_LO -> [IO_UPD] -> IDLE.
//   IDLE: if any req_valid, grant one: req_ready high for exactly that cycle, latch addr/data/
//     update, then LOAD. Both valid: grant the one not granted last. req_ready is 0 outside IDLE.
//   Register length L (bytes) from addr: 0x00:1, 0x01:3, 0x02:2, 0x03:3, 0x04:4, 0x05:2,
//     0x06:3, 0x07:2, 0x08-0x18:4. Addr 0x19-0x1F: accepted, err_addr set, no frame, -> IDLE.
//   Frame: nibble0 = 0,addr[4:4]... i.e. instruction byte {R/W=0, 2'b00, addr}, high nibble
//     at nibble0, low nibble at nibble1; then the low L bytes of data, MSB nibble first from
//     nibble2. Unused nibbles 0. packs_to_send = 2 + 2*L (4..10). Data bits above 8*L ignored.
//   LOAD: spi_data_input/packs stable from this cycle until return to IDLE; spi_trigger = 1
//     for one cycle -> WAIT_HI. Trigger asserted 1 cycle after the grant cycle.
//   WAIT_HI: wait for spi_busy=1 -> WAIT_LO. Counter from trigger; reaching BUSY_TIMEOUT
//     without busy sets err_timeout, -> IDLE (no io_update).
//   WAIT_LO: wait for spi_busy=0 -> IO_UPD if latched update (macro on), else IDLE.
//   IO_UPD: io_update high exactly IO_UPDATE_WIDTH cycles, then IDLE.
//   Next grant earliest the cycle after return to IDLE (one idle cycle between frames).
//   Reset mid-operation: FSM to IDLE next edge, trigger/io_update drop; the serializer is not
//     aborted here; a new grant still waits in WAIT_HI/WAIT_LO for its busy cycle.
//   err_addr/err_timeout clear only on reset.
// CONFIGURATION
//   AD9958_AUTO_IO_UPDATE_EN defined: IO_UPD state exists, req_update honoured as above.
//   Not defined: no IO_UPD state, io_update tied 0, req_update ignored; WAIT_LO -> IDLE.
// TESTING
//   Req0 addr 0x04 data 0x12345678 update=0 -> trigger 1 cycle after grant, packs=10,
//     nibbles 0..9 = 0,4,1,2,3,4,5,6,7,8; no io_update.
//   Req0 and req1 valid same cycle, twice each -> grants 0,1,0,1; each ready is 1 cycle wide.
//   Req1 addr 0x00 data 0xFFFFFFA5 -> packs=4, nibbles 0,0,A,5, rest 0.
//   Req0 addr 0x1A -> ready, err_addr=1, no spi_trigger, back in IDLE in 2 cycles.
//   spi_busy held 0 after trigger -> err_timeout=1 after BUSY_TIMEOUT cycles, FSM IDLE.
//   Macro on, update=1, addr 0x05 -> io_update high 4 cycles starting the cycle after busy
//     falls; assert reset mid-WAIT_LO -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/ad9958_write_scheduler.sv
// Purpose : round-robin share of the four-bit SPI serializer between host (0) and sweep engine (1) register writes.
// Latency : spi_trigger 1 cycle after grant; back to IDLE the cycle after spi_busy falls (or after the io_update pulse).
// Backpressure: req_ready is offered only in IDLE, one requester per cycle; requesters hold req_valid until granted.
//
// Ports:
//   clock, reset                 system clock, synchronous active-high reset
//   req_valid/req_ready [1:0]    per-requester handshake (transfer when valid && ready)
//   req_addr [9:0]               {addr1, addr0}, 5-bit AD9958 register addresses
//   req_data [63:0]              {data1, data0}, right-justified register data
//   req_update [1:0]             per-requester: pulse io_update after the write
//   spi_busy                     serializer busy
//   spi_trigger                  one-cycle serializer start
//   spi_packs_to_send [4:0]      nibble count of the frame (4..10)
//   spi_data_input [63:0]        frame, nibble k at bits 4k+3:4k is sent k-th
//   io_update                    AD9958 IO_UPDATE pulse
//   sched_busy                   high whenever the scheduler is not IDLE
//   err_addr, err_timeout        sticky error flags, cleared by reset only
//
// Optional feature macro: AD9958_AUTO_IO_UPDATE_EN (adds the IO_UPD state and honours req_update).

module ad9958_write_scheduler #(
  parameter int BUSY_TIMEOUT    = 255,
  parameter int IO_UPDATE_WIDTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [9:0]  req_addr,
  input  logic [63:0] req_data,
  input  logic [1:0]  req_update,
  input  logic        spi_busy,
  output logic        spi_trigger,
  output logic [4:0]  spi_packs_to_send,
  output logic [63:0] spi_data_input,
  output logic        io_update,
  output logic        sched_busy,
  output logic        err_addr,
  output logic        err_timeout
);

  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

`ifdef AD9958_AUTO_IO_UPDATE_EN
  localparam int UW = (IO_UPDATE_WIDTH > 1) ? $clog2(IO_UPDATE_WIDTH) : 1;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT_HI, S_WAIT_LO, S_IO_UPD} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT_HI, S_WAIT_LO} state_t;
`endif

  state_t          state;
  logic            prio;       // requester favoured when both are valid
  logic            lat_bad;    // latched write had an out-of-range address
  logic [TW-1:0]   hi_cnt;     // cycles since trigger while waiting for busy

`ifdef AD9958_AUTO_IO_UPDATE_EN
  logic            lat_upd;
  logic [UW-1:0]   upd_cnt;
`else
  // io_update feature compiled out; req_update is deliberately ignored.
  logic            unused_req_update;
  assign unused_req_update = ^req_update;
`endif

  // Register length in bytes; addresses above 0x18 never reach framing.
  function automatic logic [2:0] reg_len(input logic [4:0] a);
    case (a)
      5'h00:               reg_len = 3'd1;
      5'h01, 5'h03, 5'h06: reg_len = 3'd3;
      5'h02, 5'h05, 5'h07: reg_len = 3'd2;
      default:             reg_len = 3'd4;
    endcase
  endfunction

  // Instruction byte {R/W=0, 2'b00, addr} in nibbles 0/1, then the low
  // len bytes of data MSB nibble first. Left-justifying the used bytes
  // lets every data nibble come from a fixed bit position.
  function automatic logic [63:0] build_frame(input logic [4:0]  a,
                                              input logic [31:0] d,
                                              input logic [2:0]  len);
    logic [63:0] f;
    logic [31:0] ds;
    f      = '0;
    f[3:0] = {3'b000, a[4]};
    f[7:4] = a[3:0];
    ds     = d << (6'd32 - {len, 3'b000});
    for (int j = 0; j < 8; j++) begin
      if (j < 2 * int'(len)) begin
        f[4*j+8 +: 4] = ds[31-4*j -: 4];
      end
    end
    return f;
  endfunction

  // Round-robin choice among the valid requesters.
  logic [1:0]  grant;
  logic        gsel;
  logic [4:0]  sel_addr;
  logic [31:0] sel_data;
  logic        sel_upd;
  logic [2:0]  sel_len;

  always_comb begin
    gsel = 1'b0;
    if (req_valid == 2'b11) begin
      gsel = prio;
    end else begin
      gsel = req_valid[1];
    end
    grant    = (|req_valid) ? (2'b01 << gsel) : 2'b00;
    sel_addr = gsel ? req_addr[9:5]   : req_addr[4:0];
    sel_data = gsel ? req_data[63:32] : req_data[31:0];
    sel_upd  = gsel ? req_update[1]   : req_update[0];
    sel_len  = reg_len(sel_addr);
  end

  // Ready must answer valid in the same cycle, so it is decoded from the
  // registered state rather than registered itself.
  assign req_ready  = (state == S_IDLE && !reset) ? grant : 2'b00;
  assign sched_busy = (state != S_IDLE);

`ifndef AD9958_AUTO_IO_UPDATE_EN
  assign io_update = 1'b0;
  logic unused_sel_upd;
  assign unused_sel_upd = sel_upd;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= S_IDLE;
      prio              <= 1'b0;
      lat_bad           <= 1'b0;
      hi_cnt            <= '0;
      spi_trigger       <= 1'b0;
      spi_packs_to_send <= '0;
      spi_data_input    <= '0;
      err_addr          <= 1'b0;
      err_timeout       <= 1'b0;
`ifdef AD9958_AUTO_IO_UPDATE_EN
      lat_upd           <= 1'b0;
      upd_cnt           <= '0;
      io_update         <= 1'b0;
`endif
    end else begin
      spi_trigger <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|req_valid) begin
            prio  <= ~gsel;
            state <= S_LOAD;
`ifdef AD9958_AUTO_IO_UPDATE_EN
            lat_upd <= sel_upd;
`endif
            if (sel_addr > 5'h18) begin
              // Accepted but not sent; frame registers keep their old value.
              lat_bad  <= 1'b1;
              err_addr <= 1'b1;
            end else begin
              lat_bad           <= 1'b0;
              spi_data_input    <= build_frame(sel_addr, sel_data, sel_len);
              spi_packs_to_send <= 5'd2 + {1'b0, sel_len, 1'b0};
              spi_trigger       <= 1'b1;
            end
          end
        end

        S_LOAD: begin
          // Trigger is high during this cycle; it counts as cycle 0.
          hi_cnt <= TW'(1);
          state  <= lat_bad ? S_IDLE : S_WAIT_HI;
        end

        S_WAIT_HI: begin
          if (spi_busy) begin
            state <= S_WAIT_LO;
          end else if (hi_cnt >= TW'(BUSY_TIMEOUT)) begin
            err_timeout <= 1'b1;
            state       <= S_IDLE;
          end else begin
            hi_cnt <= hi_cnt + TW'(1);
          end
        end

        S_WAIT_LO: begin
          if (!spi_busy) begin
`ifdef AD9958_AUTO_IO_UPDATE_EN
            if (lat_upd) begin
              io_update <= 1'b1;
              upd_cnt   <= '0;
              state     <= S_IO_UPD;
            end else begin
              state <= S_IDLE;
            end
`else
            state <= S_IDLE;
`endif
          end
        end

`ifdef AD9958_AUTO_IO_UPDATE_EN
        S_IO_UPD: begin
          if (upd_cnt == UW'(IO_UPDATE_WIDTH - 1)) begin
            io_update <= 1'b0;
            state     <= S_IDLE;
          end else begin
            upd_cnt <= upd_cnt + UW'(1);
          end
        end
`endif

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ad9958_write_scheduler.sv
// Bench for ad9958_write_scheduler: transaction-level model checked every cycle,
// plus directed literal expectations. Serializer is modelled as busy for 6
// cycles starting 2 cycles after trigger (or never, in timeout mode).

module tb_ad9958_write_scheduler;

  localparam int BT = 255;
  localparam int W  = 4;
`ifdef AD9958_AUTO_IO_UPDATE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [9:0]  req_addr = '0;
  logic [63:0] req_data = '0;
  logic [1:0]  req_update = '0;
  logic        spi_busy = 1'b0;
  logic        spi_trigger;
  logic [4:0]  spi_packs_to_send;
  logic [63:0] spi_data_input;
  logic        io_update;
  logic        sched_busy;
  logic        err_addr;
  logic        err_timeout;

  ad9958_write_scheduler #(.BUSY_TIMEOUT(BT), .IO_UPDATE_WIDTH(W)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_update(req_update),
    .spi_busy(spi_busy), .spi_trigger(spi_trigger),
    .spi_packs_to_send(spi_packs_to_send), .spi_data_input(spi_data_input),
    .io_update(io_update), .sched_busy(sched_busy),
    .err_addr(err_addr), .err_timeout(err_timeout)
  );

  initial forever #5 clock = ~clock;

  int cyc = 0;
  initial forever begin
    @(posedge clock);
    cyc++;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bound_expired(input string name);
    checks++;
    failures++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  // ---------------- reference model ----------------
  function automatic int model_len(input logic [4:0] a);
    int lens[0:8] = '{1, 3, 2, 3, 4, 2, 3, 2, 4};
    return (a <= 5'd8) ? lens[a] : 4;
  endfunction

  function automatic logic [63:0] model_frame(input logic [4:0] a, input logic [31:0] d);
    logic [3:0]  nib[$];
    logic [7:0]  instr;
    logic [7:0]  b;
    logic [63:0] f;
    int          len;
    len   = model_len(a);
    instr = {3'b000, a};
    nib.push_back(instr[7:4]);
    nib.push_back(instr[3:0]);
    for (int k = len - 1; k >= 0; k--) begin
      b = 8'(d >> (8 * k));
      nib.push_back(b[7:4]);
      nib.push_back(b[3:0]);
    end
    f = '0;
    foreach (nib[k]) f = f | (64'(nib[k]) << (4 * k));
    return f;
  endfunction

  function automatic logic [1:0] model_grant(input logic [1:0] v, input bit p);
    if (v == 2'b11) return p ? 2'b10 : 2'b01;
    return v;
  endfunction

  initial begin
    bit          started = 1'b0;
    bit          m_act = 1'b0, m_bad = 1'b0, m_upd = 1'b0, m_prio = 1'b0;
    bit          m_err_addr = 1'b0, m_err_to = 1'b0;
    int          m_t0 = 0, m_hi = -1, m_lo = -1, c;
    logic [63:0] m_frame = '0;
    logic [4:0]  m_packs = '0;
    logic [1:0]  exp_ready;
    logic [4:0]  a;
    logic [31:0] d;
    bit          idx, exp_trig, exp_io;
    forever begin
      @(negedge clock);
      c         = cyc;
      exp_ready = (!m_act && !reset) ? model_grant(req_valid, m_prio) : 2'b00;
      exp_trig  = m_act && !m_bad && (c == m_t0 + 1);
      exp_io    = m_act && m_upd && (m_lo >= 0) && (c > m_lo) && (c <= m_lo + W);
      if (started) begin
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        chk("sched_busy", 64'(sched_busy), 64'(m_act));
        chk("spi_trigger", 64'(spi_trigger), 64'(exp_trig));
        chk("io_update", 64'(io_update), 64'(exp_io));
        chk("err_addr", 64'(err_addr), 64'(m_err_addr));
        chk("err_timeout", 64'(err_timeout), 64'(m_err_to));
        if (m_act && !m_bad) begin
          chk("packs", 64'(spi_packs_to_send), 64'(m_packs));
          chk("frame", spi_data_input, m_frame);
        end
      end
      if (reset) begin
        m_act = 0; m_prio = 0; m_err_addr = 0; m_err_to = 0;
        started = 1'b1;
      end else if (!m_act) begin
        if (exp_ready != 2'b00) begin
          idx    = exp_ready[1];
          a      = idx ? req_addr[9:5] : req_addr[4:0];
          d      = idx ? req_data[63:32] : req_data[31:0];
          m_upd  = AUTO && req_update[idx];
          m_act  = 1; m_t0 = c; m_hi = -1; m_lo = -1;
          m_prio = !idx;
          m_bad  = (a > 5'd24);
          if (m_bad) m_err_addr = 1;
          else begin
            m_frame = model_frame(a, d);
            m_packs = 5'(2 + 2 * model_len(a));
          end
        end
      end else if (m_bad) begin
        if (c == m_t0 + 1) m_act = 0;
      end else if (c <= m_t0 + 1) begin
        // trigger cycle, nothing awaited yet
      end else if (m_hi < 0) begin
        if (spi_busy) m_hi = c;
        else if (c - (m_t0 + 1) >= BT) begin
          m_err_to = 1; m_act = 0;
        end
      end else if (m_lo < 0) begin
        if (!spi_busy) begin
          m_lo = c;
          if (!m_upd) m_act = 0;
        end
      end else if (c >= m_lo + W) begin
        m_act = 0;
      end
    end
  end

  // ---------------- serializer model ----------------
  bit spi_never = 1'b0;
  initial begin
    int hf = -10, ht = -20;
    forever begin
      @(posedge clock);
      #1;
      if (spi_trigger && !spi_never) begin
        hf = cyc + 2;
        ht = cyc + 7;
      end
      spi_busy = (cyc >= hf) && (cyc <= ht);
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_req(input int idx, input logic [4:0] a, input logic [31:0] d,
                        input bit u, output int gcyc);
    @(posedge clock); #1;
    req_addr[idx*5 +: 5]    = a;
    req_data[idx*32 +: 32]  = d;
    req_update[idx]         = u;
    req_valid[idx]          = 1'b1;
    gcyc = -1;
    for (int n = 0; n < 600; n++) begin
      @(negedge clock);
      if (req_ready[idx]) begin
        gcyc = cyc;
        break;
      end
    end
    if (gcyc < 0) bound_expired("grant");
    @(posedge clock); #1;
    req_valid[idx] = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clock);
      if (!sched_busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) bound_expired("wait_idle");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, ic, idle_c;
    int got[4];
    int ngr[2];
    bit seen;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Reset values
    @(negedge clock);
    chk("rst_ready", 64'(req_ready), 64'(0));
    chk("rst_trigger", 64'(spi_trigger), 64'(0));
    chk("rst_packs", 64'(spi_packs_to_send), 64'(0));
    chk("rst_frame", spi_data_input, 64'(0));
    chk("rst_io", 64'(io_update), 64'(0));
    chk("rst_busy", 64'(sched_busy), 64'(0));
    chk("rst_err_addr", 64'(err_addr), 64'(0));
    chk("rst_err_to", 64'(err_timeout), 64'(0));

    // Req0 addr 0x04: 4-byte register
    do_req(0, 5'h04, 32'h12345678, 1'b0, g);
    @(negedge clock);
    chk("t1_trig_latency", 64'(cyc - g), 64'(1));
    chk("t1_trigger", 64'(spi_trigger), 64'(1));
    chk("t1_packs", 64'(spi_packs_to_send), 64'(10));
    chk("t1_frame", spi_data_input, 64'h0000_0087_6543_2140);
    wait_idle();

    // Req1 addr 0x00: 1-byte register, upper data ignored
    do_req(1, 5'h00, 32'hFFFFFFA5, 1'b0, g);
    @(negedge clock);
    chk("t3_packs", 64'(spi_packs_to_send), 64'(4));
    chk("t3_frame", spi_data_input, 64'h0000_0000_0000_5A00);
    wait_idle();

    // Both requesters valid, two writes each
    @(posedge clock); #1;
    req_addr   = {5'h02, 5'h07};
    req_data   = {32'h0000_1111, 32'h0000_2222};
    req_update = 2'b00;
    req_valid  = 2'b11;
    ngr = '{0, 0};
    for (int k = 0; k < 4; k++) begin
      seen = 1'b0;
      for (int n = 0; n < 100; n++) begin
        @(negedge clock);
        if (req_ready != 2'b00) begin
          seen = 1'b1;
          break;
        end
      end
      if (!seen) begin
        bound_expired("rr_grant");
        got[k] = -1;
      end else begin
        got[k] = int'(req_ready[1]);
        ngr[got[k]]++;
      end
      @(posedge clock); #1;
      if (seen) begin
        if (ngr[got[k]] == 2) req_valid[got[k]] = 1'b0;
        else req_data[got[k]*32 +: 32] = req_data[got[k]*32 +: 32] + 32'd1;
      end
    end
    req_valid = 2'b00;
    chk("rr_grant0", 64'(got[0]), 64'(0));
    chk("rr_grant1", 64'(got[1]), 64'(1));
    chk("rr_grant2", 64'(got[2]), 64'(0));
    chk("rr_grant3", 64'(got[3]), 64'(1));
    wait_idle();

    // Out-of-range address
    do_req(0, 5'h1A, 32'hDEADBEEF, 1'b0, g);
    @(negedge clock);
    chk("bad_busy_g1", 64'(sched_busy), 64'(1));
    chk("bad_err_addr", 64'(err_addr), 64'(1));
    chk("bad_no_trigger", 64'(spi_trigger), 64'(0));
    @(negedge clock);
    chk("bad_idle_g2", 64'(sched_busy), 64'(0));

    // Serializer never goes busy
    spi_never = 1'b1;
    do_req(0, 5'h01, 32'h00ABCDEF, 1'b0, g);
    idle_c = -1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clock);
      if (!sched_busy) begin
        idle_c = cyc;
        break;
      end
    end
    if (idle_c < 0) bound_expired("timeout_idle");
    else chk("timeout_cycles", 64'(idle_c - (g + 1)), 64'(BT + 1));
    chk("timeout_flag", 64'(err_timeout), 64'(1));
    spi_never = 1'b0;

    // Update requested, addr 0x05
    do_req(0, 5'h05, 32'h0000BEEF, 1'b1, g);
    @(negedge clock);
    chk("upd_packs", 64'(spi_packs_to_send), 64'(6));
    chk("upd_frame", spi_data_input, 64'h0000_0000_00FE_EB50);
    seen = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clock);
      if (spi_busy) seen = 1'b1;
      if (seen && !spi_busy) break;
    end
    if (!seen) bound_expired("upd_busy");
    ic = 0;
    for (int n = 0; n < W + 3; n++) begin
      @(negedge clock);
      if (io_update) ic++;
    end
    chk("upd_io_cycles", 64'(ic), AUTO ? 64'(W) : 64'(0));
    wait_idle();

    // Reset while waiting for busy to fall
    do_req(1, 5'h05, 32'h00001234, 1'b1, g);
    seen = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clock);
      if (spi_busy) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) bound_expired("mid_busy");
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("mid_rst_busy", 64'(sched_busy), 64'(0));
    chk("mid_rst_trigger", 64'(spi_trigger), 64'(0));
    chk("mid_rst_io", 64'(io_update), 64'(0));
    chk("mid_rst_packs", 64'(spi_packs_to_send), 64'(0));
    chk("mid_rst_frame", spi_data_input, 64'(0));
    chk("mid_rst_err_addr", 64'(err_addr), 64'(0));
    chk("mid_rst_err_to", 64'(err_timeout), 64'(0));
    chk("mid_rst_ready", 64'(req_ready), 64'(0));

    // Highest valid address after reset
    repeat (10) @(posedge clock);
    do_req(1, 5'h18, 32'hCAFEF00D, 1'b0, g);
    @(negedge clock);
    chk("max_packs", 64'(spi_packs_to_send), 64'(10));
    chk("max_frame", spi_data_input, 64'h0000_00D0_0FEF_AC81);
    wait_idle();
    repeat (3) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
